i2c_config_sequencer: RTL and testbench

- Walks a table of register writes and replays each one through the existing I2C controller as a two-byte write: register address, then data.
- Brings up the audio codec after reset, or on request, without CPU involvement.
- Sits between a combinational config table (ROM or LUT) and the I2C controller's enable/mode/periph_addr/input_byte/ready/write_in_progress pins.
- Adds an inter-transaction gap and a watchdog timeout.

---
 rtl/i2c_config_sequencer.sv | 157 +++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// Replays a register table through an I2C byte-write controller,
// one two-byte write (register address, data) per table entry.
module i2c_config_sequencer #(
    parameter int NUM_ENTRIES    = 10,
    parameter int IDX_W          = 4,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       dev_addr,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_entry,
    output logic             i2c_enable,
    output logic             i2c_mode,
    output logic [6:0]       i2c_addr,
    output logic [7:0]       i2c_byte,
    input  logic             i2c_ready,
    input  logic             i2c_wip,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, SEND_REG, SEND_DATA,
        WAIT_STOP, GAP, DONE, ERR
    } state_t;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  GAP_LAST = TO_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    state_t           r_state, w_state;
    logic [TO_W-1:0]  r_cnt, w_cnt;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [6:0]       r_addr, w_addr;
    logic [7:0]       r_byte, w_byte;
    logic             r_en, w_en;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_err, w_err;
    logic             r_mode;
    logic             r_wip_q;
    logic             w_wip_rise;
    logic             w_wait;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt + 1'b1;
        w_idx      = r_idx;
        w_addr     = r_addr;
        w_byte     = r_byte;
        w_en       = r_en;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err      = r_err;
        w_wip_rise = i2c_wip & ~r_wip_q;
        w_wait     = (r_state == WAIT_RDY) || (r_state == SEND_REG) ||
                     (r_state == SEND_DATA) || (r_state == WAIT_STOP);

        unique case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (start) begin
                    w_state = WAIT_RDY;
                    w_idx   = '0;
                    w_err   = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            WAIT_RDY: if (i2c_ready) begin
                w_state = SEND_REG;
                w_addr  = dev_addr;
                w_byte  = tbl_entry[15:8];
                w_en    = 1'b1;
            end
            SEND_REG: if (w_wip_rise) begin
                w_state = SEND_DATA;
                w_byte  = tbl_entry[7:0];
            end
            // Enable stays high so the controller chains the data byte.
            SEND_DATA: if (w_wip_rise) begin
                w_state = WAIT_STOP;
                w_en    = 1'b0;
            end
            WAIT_STOP: if (i2c_ready && !i2c_wip) begin
                w_state = GAP;
            end
            GAP: if (r_cnt == GAP_LAST) begin
                if (r_idx == IDX_LAST) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_state = WAIT_RDY;
                    w_idx   = r_idx + 1'b1;
                end
            end
            DONE:    w_state = IDLE;
            ERR:     w_state = IDLE;
            default: w_state = IDLE;
        endcase

        // Progress wins over a timeout that lands on the same cycle.
        if (w_wait && (w_state == r_state) && (r_cnt == TO_LAST)) begin
            w_state = ERR;
            w_en    = 1'b0;
            w_err   = 1'b1;
            w_busy  = 1'b0;
        end

        if (w_state != r_state) begin
            w_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_byte  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_mode  <= 1'b1;
            r_wip_q <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_addr  <= w_addr;
            r_byte  <= w_byte;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_mode  <= 1'b1;
            r_wip_q <= i2c_wip;
        end
    end

    assign tbl_index  = r_idx;
    assign i2c_enable = r_en;
    assign i2c_mode   = r_mode;
    assign i2c_addr   = r_addr;
    assign i2c_byte   = r_byte;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: bus-level controller model, timestamp
// predictor compared every cycle, plus directed scenario checks.
module tb_i2c_config_sequencer;

    localparam int GAP = 64;
    localparam int TO  = 4096;
    localparam int BIT = 2;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_XFER = 2;
    localparam int P_STOP = 3;
    localparam int P_GAP  = 4;
    localparam int P_DONE = 5;
    localparam int P_ERR  = 6;

    typedef struct {
        logic [6:0] a;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
    } wr_t;

    logic clk;
    logic reset;
    logic sel;
    logic stuck;
    logic start_a, start_b;
    logic [6:0] dev_addr;
    logic c_ready, c_wip;

    logic [3:0]  idx_a, idx_b;
    logic [15:0] ent_a, ent_b;
    logic        en_a, en_b, mode_a, mode_b;
    logic [6:0]  addr_a, addr_b;
    logic [7:0]  byte_a, byte_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    logic       bus_en, bus_mode, act_busy, act_done, act_err;
    logic [6:0] bus_addr;
    logic [7:0] bus_byte;
    logic [3:0] act_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    wr_t exp_q[$];
    int  en_q[$];
    int  stop_q[$];
    int  n_writes, n_done, t_done, t_err;

    int         ph, nr, t_ph, el;
    logic       m_busy, m_done, m_err, m_en;
    int         m_idx;
    logic [6:0] m_addr;
    logic [7:0] m_byte;
    logic       p_wip, p_en, p_err, rise, abort, s_start;
    logic [15:0] tv;
    wr_t        w;

    logic       b_active, more;
    logic [6:0] b_addr;
    logic       b_mode;
    logic [7:0] b_bytes [0:3];
    int         b_n;

    function automatic logic [15:0] tbl_val(input logic s, input int i);
        if (s) return (i == 0) ? 16'h0F00 : 16'hBEEF;
        case (i)
            0:       return 16'h1E00;
            1:       return 16'h0C10;
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb begin
        ent_a = tbl_val(1'b0, int'(idx_a));
        ent_b = tbl_val(1'b1, int'(idx_b));
    end

    assign bus_en   = sel ? en_b   : en_a;
    assign bus_mode = sel ? mode_b : mode_a;
    assign bus_addr = sel ? addr_b : addr_a;
    assign bus_byte = sel ? byte_b : byte_a;
    assign act_busy = sel ? busy_b : busy_a;
    assign act_done = sel ? done_b : done_a;
    assign act_err  = sel ? err_b  : err_a;
    assign act_idx  = sel ? idx_b  : idx_a;

    i2c_config_sequencer #(.NUM_ENTRIES(2)) u_dut (
        .clk(clk), .reset(reset), .start(start_a),
        .dev_addr(dev_addr), .tbl_index(idx_a), .tbl_entry(ent_a),
        .i2c_enable(en_a), .i2c_mode(mode_a), .i2c_addr(addr_a),
        .i2c_byte(byte_a), .i2c_ready(c_ready), .i2c_wip(c_wip),
        .busy(busy_a), .done(done_a), .error(err_a)
    );

    i2c_config_sequencer #(.NUM_ENTRIES(1)) u_one (
        .clk(clk), .reset(reset), .start(start_b),
        .dev_addr(dev_addr), .tbl_index(idx_b), .tbl_entry(ent_b),
        .i2c_enable(en_b), .i2c_mode(mode_b), .i2c_addr(addr_b),
        .i2c_byte(byte_b), .i2c_ready(c_ready), .i2c_wip(c_wip),
        .busy(busy_b), .done(done_b), .error(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    task automatic check_write();
        wr_t e;
        chk("bus_write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bus_addr", 32'(b_addr), 32'(e.a));
            chk("bus_mode", 32'(b_mode), 32'd1);
            chk("bus_nbytes", 32'(b_n), 32'(e.n));
            chk("bus_byte0", 32'(b_bytes[0]), 32'(e.b0));
            if (e.n > 1) chk("bus_byte1", 32'(b_bytes[1]), 32'(e.b1));
        end
    endtask

    // Controller model: drops ready on enable, raises wip as each byte
    // is latched, chains bytes while enable holds, then STOP.
    initial begin : bus
        c_ready  = 1'b1;
        c_wip    = 1'b0;
        b_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!stuck && bus_en === 1'b1 && c_ready) begin
                b_active = 1'b1;
                c_ready  = 1'b0;
                b_addr   = bus_addr;
                b_mode   = bus_mode;
                b_n      = 0;
                repeat (9 * BIT) @(negedge clk);
                more = 1'b1;
                while (more) begin
                    b_bytes[b_n] = bus_byte;
                    b_n++;
                    c_wip = 1'b1;
                    repeat (8 * BIT) @(negedge clk);
                    c_wip = 1'b0;
                    repeat (BIT) @(negedge clk);
                    more = bus_en && (b_n < 4);
                end
                repeat (2 * BIT) @(negedge clk);
                c_ready  = 1'b1;
                b_active = 1'b0;
                stop_q.push_back(cyc);
                n_writes++;
                check_write();
            end
        end
    end

    // Predictor: phases advance on observed bus events; waits and the
    // gap are measured as elapsed edges since the phase began.
    always begin : cmp
        @(posedge clk);
        #1;
        cyc++;
        s_start = sel ? start_b : start_a;
        rise    = c_wip && !p_wip;
        p_wip   = reset ? c_wip : 1'b0;
        m_done  = 1'b0;
        abort   = 1'b0;
        el      = cyc - t_ph;
        if (!reset) begin
            if (ph == P_XFER && nr == 1 && exp_q.size() > 0) begin
                w = exp_q.pop_back();
                w.n = 1;
                exp_q.push_back(w);
            end
            ph = P_IDLE; m_busy = 0; m_err = 0; m_idx = 0;
            m_en = 0; m_addr = '0; m_byte = '0;
        end else begin
            case (ph)
                P_IDLE: if (s_start) begin
                    ph = P_ARM; t_ph = cyc;
                    m_busy = 1; m_err = 0; m_idx = 0;
                end
                P_ARM: if (c_ready) begin
                    ph = P_XFER; t_ph = cyc; nr = 0;
                    tv = tbl_val(sel, m_idx);
                    m_en = 1; m_addr = dev_addr; m_byte = tv[15:8];
                    if (!stuck) begin
                        w.a = dev_addr; w.n = 2; w.b0 = tv[15:8]; w.b1 = tv[7:0];
                        exp_q.push_back(w);
                    end
                end else abort = (el == TO);
                P_XFER: if (rise) begin
                    nr++; t_ph = cyc;
                    tv = tbl_val(sel, m_idx);
                    if (nr == 1) m_byte = tv[7:0];
                    else begin m_en = 0; ph = P_STOP; end
                end else abort = (el == TO);
                P_STOP: if (c_ready && !c_wip) begin
                    ph = P_GAP; t_ph = cyc;
                end else abort = (el == TO);
                P_GAP: if (el == GAP) begin
                    if (m_idx == (sel ? 0 : 1)) begin
                        ph = P_DONE; m_done = 1; m_busy = 0;
                    end else begin
                        ph = P_ARM; t_ph = cyc; m_idx++;
                    end
                end
                default: ph = P_IDLE;
            endcase
            if (abort) begin
                ph = P_ERR; m_en = 0; m_err = 1; m_busy = 0;
            end
        end
        chk("busy", 32'(act_busy), 32'(m_busy));
        chk("done", 32'(act_done), 32'(m_done));
        chk("error", 32'(act_err), 32'(m_err));
        chk("tbl_index", 32'(act_idx), 32'(m_idx));
        chk("i2c_enable", 32'(bus_en), 32'(m_en));
        chk("i2c_addr", 32'(bus_addr), 32'(m_addr));
        chk("i2c_byte", 32'(bus_byte), 32'(m_byte));
        chk("i2c_mode", 32'(bus_mode), 32'd1);
        if (bus_en && !p_en) en_q.push_back(cyc);
        if (act_err && !p_err) t_err = cyc;
        if (act_done) begin n_done++; t_done = cyc; end
        p_en  = bus_en;
        p_err = act_err;
    end

    task automatic pulse(input logic s);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic new_run();
        en_q.delete(); stop_q.delete();
        n_writes = 0; n_done = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (!act_done && k < budget) begin @(negedge clk); k++; end
        chk({nm, "_done_seen"}, 32'(act_done), 32'd1);
    endtask

    task automatic wait_wip(input string nm);
        int k = 0;
        while (!c_wip && k < 500) begin @(negedge clk); k++; end
        chk({nm, "_wip_seen"}, 32'(c_wip), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        ph = P_IDLE; nr = 0; t_ph = 0; m_idx = 0;
        p_wip = 0; p_en = 0; p_err = 0;
        t_done = 0; t_err = 0;
        reset = 1'b0; sel = 1'b0; stuck = 1'b0;
        start_a = 1'b0; start_b = 1'b0; dev_addr = 7'h1A;
        new_run();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_error", 32'(err_a), 32'd0);
        chk("rst_index", 32'(idx_a), 32'd0);
        chk("rst_enable", 32'(en_a), 32'd0);
        chk("rst_mode", 32'(mode_a), 32'd1);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_byte", 32'(byte_a), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // basic two-entry run with an ignored start mid-transaction
        new_run();
        pulse(1'b0);
        wait_wip("run1");
        repeat (4) @(negedge clk);
        pulse(1'b0);
        wait_done("run1", 3000);
        pulse(1'b0);
        repeat (2) @(negedge clk);
        chk("run1_busy_after_done_start", 32'(busy_a), 32'd0);
        chk("run1_writes", 32'(n_writes), 32'd2);
        chk("run1_ndone", 32'(n_done), 32'd1);
        chk("run1_error", 32'(err_a), 32'd0);
        chk("run1_gap_ge_64", 32'(en_q.size() > 1 && stop_q.size() > 0 &&
            (en_q[1] - stop_q[0]) >= GAP), 32'd1);
        chk("run1_done_latency", 32'(stop_q.size() > 1 ?
            t_done - stop_q[1] : -1), 32'd65);

        // timeout: controller never responds
        new_run();
        stuck = 1'b1;
        pulse(1'b0);
        k = 0;
        while (!err_a && k < TO + 200) begin @(negedge clk); k++; end
        chk("to_error", 32'(err_a), 32'd1);
        chk("to_latency", 32'(en_q.size() > 0 ? t_err - en_q[0] : -1),
            32'd4096);
        chk("to_enable", 32'(en_a), 32'd0);
        chk("to_busy", 32'(busy_a), 32'd0);
        chk("to_index", 32'(idx_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("to_ndone", 32'(n_done), 32'd0);
        chk("to_error_sticky", 32'(err_a), 32'd1);

        // restart after error
        stuck = 1'b0;
        new_run();
        pulse(1'b0);
        chk("restart_error_cleared", 32'(err_a), 32'd0);
        chk("restart_busy", 32'(busy_a), 32'd1);
        wait_done("run3", 3000);
        @(negedge clk);
        chk("run3_writes", 32'(n_writes), 32'd2);
        chk("run3_ndone", 32'(n_done), 32'd1);

        // reset while the data byte is being sent
        new_run();
        pulse(1'b0);
        wait_wip("run4a");
        k = 0;
        while (c_wip && k < 100) begin @(negedge clk); k++; end
        wait_wip("run4b");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_enable", 32'(en_a), 32'd0);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_index", 32'(idx_a), 32'd0);
        k = 0;
        while (b_active && k < 500) begin @(negedge clk); k++; end
        chk("rst_mid_bus_idle", 32'(b_active), 32'd0);
        repeat (100) @(negedge clk);
        chk("rst_mid_ndone", 32'(n_done), 32'd0);
        chk("rst_mid_writes", 32'(n_writes), 32'd1);

        // single-entry instance
        sel = 1'b1;
        @(negedge clk);
        new_run();
        pulse(1'b1);
        wait_done("run5", 3000);
        @(negedge clk);
        chk("one_writes", 32'(n_writes), 32'd1);
        chk("one_ndone", 32'(n_done), 32'd1);
        chk("one_index", 32'(idx_b), 32'd0);
        chk("one_done_latency", 32'(stop_q.size() > 0 ?
            t_done - stop_q[0] : -1), 32'd65);
        chk("one_busy", 32'(busy_b), 32'd0);

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
